// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter and transaction sequencer sharing one
// spi_module master between NUM_REQ requesters.
//
// Ports:
//   i_sys_clk, i_sys_rst    clock, synchronous active-high reset
//   i_req       [NUM_REQ]   per-requester request level
//   i_req_cfg   [NUM_REQ*CFG_W]  packed config words (slot k at k*CFG_W)
//   i_req_data  [NUM_REQ*DATA_W] packed TX bytes
//   o_grant     [NUM_REQ]   one-hot grant, CONFIG through DONE
//   o_done      [NUM_REQ]   one-cycle completion pulse to the winner
//   o_rdata     [DATA_W]    received byte, valid with o_done
//   o_timeout               watchdog pulse alongside o_done
//   o_spi_config/o_spi_data/o_spi_trans_en  drive spi_module
//   i_spi_interrupt, i_spi_rdata            from spi_module
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYC cycles). Without it o_timeout is tied to 0.
module spi_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int CFG_W       = 32,
  parameter int CFG_SETTLE  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*CFG_W-1:0]  i_req_cfg,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_timeout,
  output logic [CFG_W-1:0]          o_spi_config,
  output logic [DATA_W-1:0]         o_spi_data,
  output logic                      o_spi_trans_en,
  input  logic                      i_spi_interrupt,
  input  logic [DATA_W-1:0]         i_spi_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SET_W = (CFG_SETTLE > 1) ? $clog2(CFG_SETTLE + 1) : 1;

  typedef enum logic [2:0] {IDLE, CONFIG, START, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, win, pick;
  logic               any_req;
  logic [SET_W-1:0]   settle_cnt;
  logic               settle_last;
  logic               to_hit;
  logic [NUM_REQ-1:0] win_oh;

  // Round-robin pick: scan offsets from high to low so the smallest offset
  // from rr_ptr (the highest-priority requester) is the last writer.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req[j[IDX_W-1:0]]) begin
        pick    = j[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign settle_last = (settle_cnt == SET_W'(CFG_SETTLE - 1));

`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0] wdog;
  logic        to_flag;
  assign to_hit    = (wdog == 32'(TIMEOUT_CYC - 1));
  assign o_timeout = (state == DONE) && to_flag;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CONFIG;
      CONFIG:  if (settle_last) state_nxt = START;
      START:   state_nxt = WAIT;
      // The interrupt takes precedence over a simultaneous watchdog expiry.
      WAIT:    if (i_spi_interrupt || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: transaction operands are latched only at the grant, so the
  // SPI-facing values stay stable through the transfer and after it.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      rr_ptr       <= '0;
      win          <= '0;
      settle_cnt   <= '0;
      o_spi_config <= '0;
      o_spi_data   <= '0;
      o_rdata      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog         <= '0;
      to_flag      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          win          <= pick;
          o_spi_config <= i_req_cfg[pick*CFG_W +: CFG_W];
          o_spi_data   <= i_req_data[pick*DATA_W +: DATA_W];
          settle_cnt   <= '0;
        end
        CONFIG: settle_cnt <= settle_cnt + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        START: begin
          wdog    <= '0;
          to_flag <= 1'b0;
        end
        WAIT: begin
          wdog <= wdog + 32'd1;
          if (i_spi_interrupt) begin
            o_rdata <= i_spi_rdata;
          end else if (to_hit) begin
            o_rdata <= '0;
            to_flag <= 1'b1;
          end
        end
`else
        WAIT: if (i_spi_interrupt) o_rdata <= i_spi_rdata;
`endif
        DONE: rr_ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        default: ;
      endcase
    end
  end

  assign win_oh         = NUM_REQ'(1) << win;
  assign o_grant        = (state != IDLE) ? win_oh : '0;
  assign o_done         = (state == DONE) ? win_oh : '0;
  assign o_spi_trans_en = (state == START);

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus a random
// transaction loop, checked against a transaction-level round-robin model.
module tb_spi_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int CS = 2;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req;
  logic [NR*CW-1:0]   req_cfg;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      grant, done;
  logic [DW-1:0]      rdata;
  logic               tmo;
  logic [CW-1:0]      spi_cfg;
  logic [DW-1:0]      spi_data;
  logic               spi_ten;
  logic               irq;
  logic [DW-1:0]      spi_rdata;

  int checks = 0;
  int errs   = 0;
  int m_ptr  = 0;

  spi_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CFG_W(CW), .CFG_SETTLE(CS),
                .TIMEOUT_CYC(TO)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_req(req), .i_req_cfg(req_cfg),
    .i_req_data(req_data), .o_grant(grant), .o_done(done), .o_rdata(rdata),
    .o_timeout(tmo), .o_spi_config(spi_cfg), .o_spi_data(spi_data),
    .o_spi_trans_en(spi_ten), .i_spi_interrupt(irq), .i_spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first set bit at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      int j = (m_ptr + i) % NR;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_cfg"}, spi_cfg, 0);
    chk({tag, "_data"}, spi_data, 0);
    chk({tag, "_ten"}, spi_ten, 0);
  endtask

  // One full transaction, starting in an IDLE cycle. dly = WAIT cycles
  // without interrupt before it fires; dly<0 means never (watchdog).
  task automatic txn(input logic [NR-1:0] r, input int dly, input logic [NR-1:0] drop,
                     input bit stale, input logic [CW-1:0] cfgv,
                     input logic [DW-1:0] datv, input logic [DW-1:0] rdv);
    int w;
    logic [NR-1:0] oh;
    w  = model_pick(r);
    oh = '0;
    oh[w] = 1'b1;
    req      = r;
    req_cfg  = {$urandom, $urandom, $urandom, $urandom};
    req_data = $urandom;
    req_cfg[w*CW +: CW] = cfgv;
    req_data[w*DW +: DW] = datv;
    irq = stale;
    step();                                  // first CONFIG cycle
    req_cfg  = ~req_cfg;                     // must be ignored after grant
    req_data = ~req_data;
    chk("grant", grant, oh);
    chk("cfg", spi_cfg, cfgv);
    chk("data", spi_data, datv);
    chk("ten_early", spi_ten, 0);
    for (int k = 1; k < CS; k++) begin
      step();
      chk("ten_settle", spi_ten, 0);
      chk("grant_settle", grant, oh);
    end
    step();                                  // START
    chk("ten", spi_ten, 1);
    chk("grant_start", grant, oh);
    step();                                  // first WAIT cycle
    irq = 1'b0;
    chk("ten_wait", spi_ten, 0);
    if (dly >= 0) begin
      for (int k = 0; k < dly; k++) begin
        if (k == dly / 2) req = req & ~drop;
        step();
        chk("no_done", done, 0);
        chk("grant_wait", grant, oh);
      end
      irq = 1'b1;
      spi_rdata = rdv;
      step();                                // DONE
      irq = 1'b0;
      spi_rdata = $urandom;
      chk("done", done, oh);
      chk("rdata", rdata, rdv);
      chk("tmo_clear", tmo, 0);
      chk("cfg_hold", spi_cfg, cfgv);
    end else begin
      int n = 0;
      while (done == 0 && n < 200) begin
        step();
        n++;
      end
      chk("to_cycles", n, TO);
      chk("to_done", done, oh);
      chk("to_flag", tmo, 1);
      chk("to_rdata", rdata, 0);
    end
    m_ptr = (w + 1) % NR;
    step();                                  // back in IDLE
    chk("idle_grant", grant, 0);
    chk("idle_done", done, 0);
    chk("idle_cfg_hold", spi_cfg, cfgv);
    chk("idle_data_hold", spi_data, datv);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_cfg = '0; req_data = '0; irq = 1'b0; spi_rdata = '0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_no_req", grant, 0);

    // Single request with the fixed operands.
    txn(4'b0010, 3, 4'b0000, 1'b0, 32'hD6108011, 8'hA5, 8'h3C);

    // All four requesting continuously from reset: 0,1,2,3,0.
    rst = 1'b1; req = '0; step(); rst = 1'b0; m_ptr = 0;
    for (int t = 0; t < 5; t++)
      txn(4'b1111, $urandom_range(0, 3), 4'b0000, 1'b0, $urandom, $urandom, $urandom);

    // Requester 2 drops its request mid-WAIT; next winner is after 2.
    txn(4'b0101, 4, 4'b0100, 1'b0, $urandom, $urandom, $urandom);
    txn(4'b1001, 1, 4'b0000, 1'b0, $urandom, $urandom, $urandom);

    // Stale interrupt during IDLE/CONFIG/START; real one at WAIT cycle 5.
    txn(4'b0001, 4, 4'b0000, 1'b1, $urandom, $urandom, $urandom);

    // Reset during WAIT aborts; arbitration restarts at requester 0.
    req = 4'b1110;
    step(); step(); step(); step();          // CONFIG x2, START, WAIT
    chk("pre_reset_grant", grant != 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; req = '0;
    chk_all_zero("mid_reset");
    m_ptr = 0;
    step();
    chk("post_reset_done", done, 0);
    txn(4'b1111, 2, 4'b0000, 1'b0, $urandom, $urandom, $urandom);

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      logic [NR-1:0] r;
      int d;
      r = NR'($urandom_range(1, (1 << NR) - 1));
      d = $urandom_range(0, 6);
      txn(r, d, (d >= 2) ? (r & NR'($urandom)) : '0, 1'($urandom),
          $urandom, $urandom, $urandom);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog expiry, then a normal transfer.
    txn(4'b0100, -1, 4'b0000, 1'b0, $urandom, $urandom, $urandom);
    txn(4'b0100, 2, 4'b0000, 1'b0, $urandom, $urandom, 8'h5A);
`endif

    req = '0;
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
